instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 196 +++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Assembles a byte stream (MSB of each word first) into 32-bit instruction
//   words and writes them sequentially into an instruction memory starting at
//   address 0. The CPU is held off via busy while a load is in progress.
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a load at address 0 (honoured only when idle)
//   byte_valid  in   byte_data/byte_last are valid
//   byte_data   in   program byte
//   byte_last   in   final byte of the program image
//   byte_ready  out  a byte is accepted this cycle
//   wr_en       out  instruction-memory write strobe (one cycle per word)
//   wr_addr     out  instruction-memory word address
//   wr_data     out  assembled instruction word
//   busy        out  load in progress
//   done        out  one-cycle completion pulse
//   error       out  sticky: image ended mid-word or filled all DEPTH words
//   word_cnt    out  words written in the current or most recent load
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_e;

  // word_cnt value while the final permitted word is being written
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [23:0]         word_q, word_d;     // bytes received so far, right-aligned
  logic [1:0]          idx_q, idx_d;
  logic                last_q, last_d;     // word being written ends the image
  logic                ready_q, ready_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;

  logic                xfer;
  logic [31:0]         padded;

  assign xfer = byte_valid && ready_q;

  // Word as it would look if the current byte closes it; an early byte_last
  // leaves the unfilled low bytes as zero.
  always_comb begin
    padded = '0;
    case (idx_q)
      2'd0:    padded = {byte_data, 24'h0};
      2'd1:    padded = {word_q[7:0], byte_data, 16'h0};
      2'd2:    padded = {word_q[15:0], byte_data, 8'h0};
      default: padded = {word_q[23:0], byte_data};
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    last_d  = last_q;
    ready_d = ready_q;
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          addr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          last_d  = 1'b0;
          ready_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      RECV: begin
        if (xfer) begin
          word_d = {word_q[15:0], byte_data};
          idx_d  = idx_q + 2'd1;
          if (byte_last || idx_q == 2'd3) begin
            state_d = WRITE;
            ready_d = 1'b0;
            wr_en_d = 1'b1;
            wdata_d = padded;
            last_d  = byte_last;
            if (byte_last && idx_q != 2'd3) begin
              err_d = 1'b1;
            end
          end
        end
      end

      WRITE: begin
        wr_en_d = 1'b0;
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = '0;
        if (last_q || cnt_q == LAST_CNT) begin
          state_d = DONE;
          done_d  = 1'b1;
          // memory filled without the image announcing its end
          if (!last_q) begin
            err_d = 1'b1;
          end
        end else begin
          state_d = RECV;
          ready_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_ready = ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
//   Directed bench for instr_mem_loader: single word, multi-word throughput,
//   short image padding, DEPTH overflow, mid-load reset, and gappy stream with
//   start pulses while busy.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  word_cnt;

  instr_mem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // write / done monitor, sampled on the falling edge
  int          cyc = 0;
  logic [7:0]  wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];
  int          done_cnt = 0;
  int          dbl_wr = 0;
  int          dbl_done = 0;
  logic        wr_prev = 1'b0;
  logic        done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
    end
    if (wr_en && wr_prev) dbl_wr++;
    if (done && done_prev) dbl_done++;
    if (done) done_cnt++;
    wr_prev   = wr_en;
    done_prev = done;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    dbl_wr   = 0;
    dbl_done = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte and hold it until it transfers; returns the cycle index
  // of the transferring edge. Back-to-back calls keep byte_valid high.
  task automatic put(input logic [7:0] b, input logic last, output int tx_cyc);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) check("byte_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    tx_cyc     = cyc;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("done_pulse", 64'(done_cnt), 64'(prev + 1));
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {59'd0, byte_ready, wr_en, busy, done, error}, 64'd0);
    check({tag, "_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_data"}, 64'(wr_data), 64'd0);
    check({tag, "_cnt"}, 64'(word_cnt), 64'd0);
  endtask

  initial begin
    int t;
    int d0;
    logic [7:0] bytes_a[4];
    logic [31:0] exp_w;

    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = '0;
    byte_last = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_wait", {62'd0, busy, byte_ready}, 64'd0);

    // single word 8C010004
    clear_mon();
    d0 = done_cnt;
    bytes_a = '{8'h8C, 8'h01, 8'h00, 8'h04};
    do_start();
    for (int i = 0; i < 4; i++) put(bytes_a[i], i == 3, t);
    wait_done(d0);
    check("a_nwr", 64'(wq_addr.size()), 64'd1);
    if (wq_addr.size() >= 1) begin
      check("a_addr", 64'(wq_addr[0]), 64'd0);
      check("a_data", 64'(wq_data[0]), 64'h8C010004);
      check("a_latency", 64'(wq_cyc[0]), 64'(t));
    end
    check("a_cnt", 64'(word_cnt), 64'd1);
    check("a_err", 64'(error), 64'd0);
    check("a_busy", 64'(busy), 64'd0);
    check("a_wr_1cyc", 64'(dbl_wr), 64'd0);
    check("a_done_1cyc", 64'(dbl_done), 64'd0);
    check("a_hold_data", 64'(wr_data), 64'h8C010004);

    // twelve bytes, continuous valid
    clear_mon();
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 12; i++) put(8'(i), i == 11, t);
    wait_done(d0);
    check("b_nwr", 64'(wq_addr.size()), 64'd3);
    if (wq_addr.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        exp_w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
        check($sformatf("b_addr%0d", k), 64'(wq_addr[k]), 64'(k));
        check($sformatf("b_data%0d", k), 64'(wq_data[k]), 64'(exp_w));
      end
      check("b_gap01", 64'(wq_cyc[1] - wq_cyc[0]), 64'd5);
      check("b_gap12", 64'(wq_cyc[2] - wq_cyc[1]), 64'd5);
    end
    check("b_cnt", 64'(word_cnt), 64'd3);
    check("b_err", 64'(error), 64'd0);

    // short image AA BB -> zero padded, error
    clear_mon();
    d0 = done_cnt;
    do_start();
    put(8'hAA, 1'b0, t);
    put(8'hBB, 1'b1, t);
    wait_done(d0);
    check("c_nwr", 64'(wq_addr.size()), 64'd1);
    if (wq_addr.size() >= 1) begin
      check("c_addr", 64'(wq_addr[0]), 64'd0);
      check("c_data", 64'(wq_data[0]), 64'hAABB0000);
    end
    check("c_err", 64'(error), 64'd1);
    check("c_cnt", 64'(word_cnt), 64'd1);
    repeat (4) @(negedge clk);
    check("c_err_sticky", 64'(error), 64'd1);
    do_start();
    check("c_err_cleared", 64'(error), 64'd0);
    check("c_cnt_cleared", 64'(word_cnt), 64'd0);

    // overflow: 1024 bytes, no byte_last (load already started above)
    clear_mon();
    d0 = done_cnt;
    for (int i = 0; i < 1024; i++) put(8'(i), 1'b0, t);
    wait_done(d0);
    check("d_nwr", 64'(wq_addr.size()), 64'd256);
    if (wq_addr.size() == 256) begin
      for (int k = 0; k < 256; k++) begin
        exp_w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
        check($sformatf("d_addr%0d", k), 64'(wq_addr[k]), 64'(k));
        check($sformatf("d_data%0d", k), 64'(wq_data[k]), 64'(exp_w));
      end
    end
    check("d_addr_wrap", 64'(wr_addr), 64'd0);
    check("d_ready", 64'(byte_ready), 64'd0);
    check("d_err", 64'(error), 64'd1);
    check("d_cnt", 64'(word_cnt), 64'd256);

    // reset after two bytes of the second word
    clear_mon();
    do_start();
    bytes_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) put(bytes_a[i], 1'b0, t);
    put(8'h99, 1'b0, t);
    put(8'h98, 1'b0, t);
    rst_n = 1'b0;
    #1;
    check_all_zero("e_rst");
    repeat (4) @(negedge clk);
    check("e_nwr", 64'(wq_addr.size()), 64'd1);
    if (wq_addr.size() >= 1) check("e_data0", 64'(wq_data[0]), 64'h11223344);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("e_idle", {62'd0, busy, byte_ready}, 64'd0);
    clear_mon();
    d0 = done_cnt;
    do_start();
    bytes_a = '{8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 4; i++) put(bytes_a[i], i == 3, t);
    wait_done(d0);
    check("e_nwr2", 64'(wq_addr.size()), 64'd1);
    if (wq_addr.size() >= 1) begin
      check("e_addr2", 64'(wq_addr[0]), 64'd0);
      check("e_data2", 64'(wq_data[0]), 64'h55667788);
    end

    // gappy valid with start pulses while busy
    clear_mon();
    d0 = done_cnt;
    do_start();
    begin
      logic [7:0] g[8];
      g = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          start = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        put(g[i], i == 7, t);
      end
    end
    wait_done(d0);
    check("f_nwr", 64'(wq_addr.size()), 64'd2);
    if (wq_addr.size() == 2) begin
      check("f_addr0", 64'(wq_addr[0]), 64'd0);
      check("f_data0", 64'(wq_data[0]), 64'hDEADBEEF);
      check("f_addr1", 64'(wq_addr[1]), 64'd1);
      check("f_data1", 64'(wq_data[1]), 64'h01234567);
    end
    check("f_cnt", 64'(word_cnt), 64'd2);
    check("f_err", 64'(error), 64'd0);
    check("f_busy", 64'(busy), 64'd0);
    check("f_wr_1cyc", 64'(dbl_wr), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
